nibble_frame_checker: RTL and testbench
=======================================

NIBBLE_FRAME_CHECKER -- requirements
Module: nibble_frame_checker

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, meaning the maximum number of nibbles per frame (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream nibble valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a nibble.
REQ-006 The block SHALL have port in_data, input, 4 bits: data nibble.
REQ-007 The block SHALL have port in_par, input, 1 bit: expected even-parity bit of in_data.
REQ-008 The block SHALL have port in_last, input, 1 bit: this nibble ends the frame early.
REQ-009 The block SHALL have port out_valid, output, 1 bit: frame result valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port out_xor, output, 4 bits: bitwise XOR of all frame nibbles.
REQ-012 The block SHALL have port out_all_ones, output, 1 bit: every frame nibble equalled 4'hF.
REQ-013 The block SHALL have port out_any_nz, output, 1 bit: at least one frame nibble was non-zero.
REQ-014 The block SHALL have port out_par_err, output, 1 bit: at least one nibble had (^in_data) != in_par.
REQ-015 The block SHALL have port out_len, output, 8 bits: number of nibbles in the frame.
REQ-016 The block SHALL have port err_cnt, output, 8 bits: count of frames with a parity error (see Configuration).

Function
REQ-017 The FSM SHALL have three states: IDLE (count=0), ACCUM (count>0) and DONE (result held).
REQ-018 A nibble SHALL be accepted only on a cycle where in_valid && in_ready are both high.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-020 On the first accepted nibble in IDLE, the accumulators SHALL load from that nibble: xor=in_data, all_ones=&in_data, any_nz=|in_data, par_err=(^in_data!=in_par), count=1.
REQ-021 On each subsequent accepted nibble: xor^=in_data, all_ones&=&in_data, any_nz|=|in_data, par_err|=mismatch, count+=1.
REQ-022 A frame SHALL end on the accepted nibble that has in_last=1 or that makes count==FRAME_LEN, whichever comes first; the FSM then enters DONE.
REQ-023 out_valid SHALL assert the cycle after the final nibble is accepted (1-cycle latency).
REQ-024 All out_* values SHALL be registered and held stable while out_valid=1.
REQ-025 DONE SHALL be left to IDLE on out_valid && out_ready, and out_valid SHALL drop the following cycle.
REQ-026 The next frame's first nibble SHALL be accepted no earlier than the cycle after the output handshake; input and output handshakes never overlap.
REQ-027 A frame consisting of a single nibble with in_last=1 SHALL be legal and give out_len=1.
REQ-028 in_data, in_par and in_last SHALL be ignored when in_valid=0 or in_ready=0.
REQ-029 out_valid SHALL hold indefinitely while out_ready=0, and no new nibbles SHALL be accepted during that time.

Reset
REQ-030 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE, count=0, out_valid=0, out_xor=0, out_all_ones=0, out_any_nz=0, out_par_err=0, out_len=0, err_cnt=0.
REQ-031 While rst_n=0, in_ready SHALL be driven 0; it returns to 1 in the first cycle after rst_n rises.
REQ-032 Reset mid-frame or in DONE SHALL discard the partial or pending result without emitting it.

Configuration
REQ-033 When macro NIBBLE_FRAME_ERR_CNT_EN is defined, err_cnt SHALL increment by 1 on each output handshake with out_par_err=1, saturating at 255.
REQ-034 When NIBBLE_FRAME_ERR_CNT_EN is undefined, err_cnt SHALL be the constant 0 and no counter register SHALL exist.

Verification
REQ-035 The bench SHALL cover a full frame with FRAME_LEN=8, nibbles 1..8, correct parity -> out_xor=4'h8, all_ones=0, any_nz=1, par_err=0, out_len=8.
REQ-036 The bench SHALL cover an early end: nibbles F,F,F with in_last on the 3rd -> out_xor=4'hF, all_ones=1, out_len=3, out_valid the cycle after the 3rd accept.
REQ-037 The bench SHALL cover a parity error: nibble 4'h3 with in_par=1 inside a frame -> par_err=1; with the macro defined err_cnt=1 after the handshake, and without it err_cnt=0.
REQ-038 The bench SHALL cover back-pressure: out_ready=0 for 5 cycles -> out_valid and outputs stable, in_ready=0, no nibble accepted; out_ready=1 -> IDLE next cycle.
REQ-039 The bench SHALL cover reset mid-frame: rst_n=0 after 4 nibbles -> no out_valid, and the next frame is reported with out_len counted from 1.
REQ-040 The bench SHALL cover saturation: 300 error frames with the macro defined -> err_cnt=255.

Source files
------------

// File: rtl/nibble_frame_checker.sv
// nibble_frame_checker
// Accepts a stream of 4-bit nibbles and groups them into frames. A frame ends
// on a nibble flagged in_last or on the FRAME_LEN-th nibble. For each frame it
// reports the XOR of all nibbles, whether every nibble was 4'hF, whether any
// nibble was non-zero, whether any nibble's parity bit disagreed with its data,
// and the frame length.
// The result is held until the downstream side accepts it. No new nibble is
// taken while a result is pending.
// Optional feature: define NIBBLE_FRAME_ERR_CNT_EN to enable a saturating
// counter of frames that had a parity error. Without it, err_cnt is tied to 0.

module nibble_frame_checker #(
   parameter int unsigned FRAME_LEN = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   input  logic       in_par,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_xor,
   output logic       out_all_ones,
   output logic       out_any_nz,
   output logic       out_par_err,
   output logic [7:0] out_len,
   output logic [7:0] err_cnt
);

   localparam logic [7:0] LP_FRAME_LEN = 8'(FRAME_LEN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   // Running accumulators for the frame in progress
   logic [3:0] r_acc_xor;
   logic       r_acc_all1;
   logic       r_acc_nz;
   logic       r_acc_perr;
   logic [7:0] r_count;

   // Registered frame result
   logic [3:0] r_out_xor;
   logic       r_out_all1;
   logic       r_out_nz;
   logic       r_out_perr;
   logic [7:0] r_out_len;

   // Accumulator values that include the current nibble
   logic [3:0] w_nxt_xor;
   logic       w_nxt_all1;
   logic       w_nxt_nz;
   logic       w_nxt_perr;
   logic [7:0] w_nxt_count;
   logic       w_mismatch;
   logic       w_final;
   logic       w_accept;
   logic       w_out_hs;

   assign w_accept = in_valid && in_ready;
   assign w_out_hs = out_valid && out_ready;

   // Fold the incoming nibble into the accumulators; the first nibble loads them
   always_comb begin
      w_mismatch = ((^in_data) != in_par);
      if (r_state == S_IDLE) begin
         w_nxt_xor   = in_data;
         w_nxt_all1  = &in_data;
         w_nxt_nz    = |in_data;
         w_nxt_perr  = w_mismatch;
         w_nxt_count = 8'd1;
      end else begin
         w_nxt_xor   = r_acc_xor ^ in_data;
         w_nxt_all1  = r_acc_all1 & (&in_data);
         w_nxt_nz    = r_acc_nz | (|in_data);
         w_nxt_perr  = r_acc_perr | w_mismatch;
         w_nxt_count = r_count + 8'd1;
      end
      // A frame closes on in_last or when it reaches its maximum length
      w_final = in_last || (w_nxt_count == LP_FRAME_LEN);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_final ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (w_accept && w_final) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (w_out_hs) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM outputs: in_ready is forced low during reset and while a result is pending
   always_comb begin
      in_ready  = rst_n && (r_state != S_DONE);
      out_valid = (r_state == S_DONE);
   end

   // Accumulators track the frame in progress; the count returns to 0 once the frame closes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc_xor  <= 4'd0;
         r_acc_all1 <= 1'b0;
         r_acc_nz   <= 1'b0;
         r_acc_perr <= 1'b0;
         r_count    <= 8'd0;
      end else if (w_accept) begin
         r_acc_xor  <= w_nxt_xor;
         r_acc_all1 <= w_nxt_all1;
         r_acc_nz   <= w_nxt_nz;
         r_acc_perr <= w_nxt_perr;
         r_count    <= w_final ? 8'd0 : w_nxt_count;
      end
   end

   // Capture the frame result on the closing nibble; it holds until the next frame closes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_xor  <= 4'd0;
         r_out_all1 <= 1'b0;
         r_out_nz   <= 1'b0;
         r_out_perr <= 1'b0;
         r_out_len  <= 8'd0;
      end else if (w_accept && w_final) begin
         r_out_xor  <= w_nxt_xor;
         r_out_all1 <= w_nxt_all1;
         r_out_nz   <= w_nxt_nz;
         r_out_perr <= w_nxt_perr;
         r_out_len  <= w_nxt_count;
      end
   end

   assign out_xor      = r_out_xor;
   assign out_all_ones = r_out_all1;
   assign out_any_nz   = r_out_nz;
   assign out_par_err  = r_out_perr;
   assign out_len      = r_out_len;

`ifdef NIBBLE_FRAME_ERR_CNT_EN
   logic [7:0] r_err_cnt;

   // Count delivered frames that carried a parity error, saturating at 255
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_cnt <= 8'd0;
      end else if (w_out_hs && r_out_perr && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_nibble_frame_checker.sv
// tb_nibble_frame_checker
// Scoreboard bench for nibble_frame_checker. Frames are generated as arrays of
// nibbles. The expected frame result is computed from the whole array and
// queued. A negedge monitor checks the handshake signals and the held outputs
// against the queue head, and pops the head on each output handshake.
// Honours NIBBLE_FRAME_ERR_CNT_EN for the error-counter expectations.

module tb_nibble_frame_checker;

   localparam int FL = 8;
`ifdef NIBBLE_FRAME_ERR_CNT_EN
   localparam int ERR_ONE = 1;
   localparam int ERR_SAT = 255;
`else
   localparam int ERR_ONE = 0;
   localparam int ERR_SAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_par;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_xor;
   logic       out_all_ones;
   logic       out_any_nz;
   logic       out_par_err;
   logic [7:0] out_len;
   logic [7:0] err_cnt;

   nibble_frame_checker #(.FRAME_LEN(FL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_par       (in_par),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_xor      (out_xor),
      .out_all_ones (out_all_ones),
      .out_any_nz   (out_any_nz),
      .out_par_err  (out_par_err),
      .out_len      (out_len),
      .err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] x;
      logic       a1;
      logic       nz;
      logic       pe;
      int         len;
   } exp_t;

   exp_t       sbq[$];
   int         checks = 0;
   int         errors = 0;
   int         exp_err = 0;
   logic       rst_prev;
   bit         or_rand = 1'b0;

   logic [3:0] fr_d[FL];
   logic       fr_p[FL];
   int         fr_n;
   bit         fr_last_full;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Remember whether the last rising edge applied reset
   always @(posedge clk) rst_prev <= rst_n;

   // Monitor: compare against the scoreboard head away from the active edge
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_prev === 1'b0) begin
         sbq.delete();
         exp_err = 0;
         check("reset_outs", {19'd0, out_xor, out_all_ones, out_any_nz, out_par_err, out_len}, 32'd0);
      end
      check("in_ready", {31'd0, in_ready}, {31'd0, (rst_n === 1'b1) && (sbq.size() == 0)});
      check("out_valid", {31'd0, out_valid}, {31'd0, sbq.size() != 0});
      check("err_cnt", {24'd0, err_cnt}, exp_err);
      if (sbq.size() != 0) begin
         e = sbq[0];
         check("out_xor", {28'd0, out_xor}, {28'd0, e.x});
         check("out_all_ones", {31'd0, out_all_ones}, {31'd0, e.a1});
         check("out_any_nz", {31'd0, out_any_nz}, {31'd0, e.nz});
         check("out_par_err", {31'd0, out_par_err}, {31'd0, e.pe});
         check("out_len", {24'd0, out_len}, e.len);
         if (out_valid === 1'b1 && out_ready === 1'b1 && rst_n === 1'b1) begin
            void'(sbq.pop_front());
`ifdef NIBBLE_FRAME_ERR_CNT_EN
            if (e.pe && exp_err < 255) exp_err++;
`endif
         end
      end
   end

   // Random back-pressure generator, active only when or_rand is set
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (or_rand) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_nib(input logic [3:0] d, input logic p, input logic l, output bit ok);
      in_valid = 1'b1;
      in_data  = d;
      in_par   = p;
      in_last  = l;
      ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         if (in_ready === 1'b1) ok = 1'b1;
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
      in_data  = 4'($urandom);
      in_par   = 1'($urandom);
      in_last  = 1'($urandom);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=no_accept required=accept t=%0t", $time);
      end
   endtask

   // Send fr_d/fr_p[0..fr_n-1]; abort_after>0 sends only that many nibbles and expects nothing
   task automatic run_frame(input int abort_after);
      exp_t e;
      bit   ok;
      int   n;
      logic l;
      e.x = 4'd0; e.a1 = 1'b1; e.nz = 1'b0; e.pe = 1'b0; e.len = fr_n;
      for (int i = 0; i < fr_n; i++) begin
         e.x  = e.x ^ fr_d[i];
         e.a1 = e.a1 & (fr_d[i] == 4'hF);
         e.nz = e.nz | (fr_d[i] != 4'h0);
         e.pe = e.pe | ((^fr_d[i]) != fr_p[i]);
      end
      n = (abort_after > 0) ? abort_after : fr_n;
      for (int i = 0; i < n; i++) begin
         l = (abort_after == 0) && (i == fr_n - 1) && (fr_n < FL || fr_last_full);
         send_nib(fr_d[i], fr_p[i], l, ok);
         if (abort_after == 0 && i == fr_n - 1) sbq.push_back(e);
         if (or_rand) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && sbq.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      check("drain", sbq.size(), 32'd0);
   endtask

   task automatic rand_frame(input int n, input bit last_full);
      fr_n = n;
      fr_last_full = last_full;
      for (int i = 0; i < n; i++) begin
         fr_d[i] = 4'($urandom);
         fr_p[i] = ^fr_d[i];
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; in_par = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Full frame 1..8, correct parity
      fr_n = 8; fr_last_full = 1'b0;
      for (int i = 0; i < 8; i++) begin fr_d[i] = 4'(i + 1); fr_p[i] = ^fr_d[i]; end
      run_frame(0);
      drain();

      // Early end: F,F,F with last on the third
      fr_n = 3;
      for (int i = 0; i < 3; i++) begin fr_d[i] = 4'hF; fr_p[i] = 1'b0; end
      run_frame(0);
      drain();

      // Parity error on nibble 3 with in_par=1
      fr_n = 3;
      fr_d[0] = 4'h5; fr_p[0] = 1'b0;
      fr_d[1] = 4'h3; fr_p[1] = 1'b1;
      fr_d[2] = 4'h6; fr_p[2] = 1'b0;
      run_frame(0);
      drain();
      check("err_after_par", {24'd0, err_cnt}, ERR_ONE);

      // Back-pressure: result held while out_ready=0, next frame waits
      out_ready = 1'b0;
      rand_frame(4, 1'b0);
      run_frame(0);
      fork
         begin
            repeat (6) begin @(posedge clk); #1; end
            out_ready = 1'b1;
         end
         begin
            rand_frame(2, 1'b0);
            run_frame(0);
         end
      join
      drain();

      // Reset after 4 nibbles of an 8-nibble frame; nothing must come out
      rand_frame(8, 1'b0);
      run_frame(4);
      rst_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      rand_frame(2, 1'b0);
      run_frame(0);
      drain();

      // Reset while a result is pending in DONE
      out_ready = 1'b0;
      rand_frame(1, 1'b0);
      run_frame(0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      // 300 single-nibble parity-error frames
      fr_n = 1; fr_d[0] = 4'h3; fr_p[0] = 1'b1;
      for (int f = 0; f < 300; f++) run_frame(0);
      drain();
      check("err_sat", {24'd0, err_cnt}, ERR_SAT);

      // Randomized frames with random gaps and back-pressure
      or_rand = 1'b1;
      for (int f = 0; f < 80; f++) begin
         rand_frame($urandom_range(1, FL), 1'($urandom));
         for (int i = 0; i < fr_n; i++) fr_p[i] = (^fr_d[i]) ^ ($urandom_range(0, 9) == 0);
         run_frame(0);
      end
      or_rand = 1'b0;
      out_ready = 1'b1;
      drain();
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL global_timeout actual=running required=finished t=%0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "global timeout");
   end

endmodule
